tlm_frame_uart_tx: RTL and testbench
====================================

Name: tlm_frame_uart_tx

Overview:
- Transmit side of the 0xFE-command / 32-parameter-byte serial link.
- On a start pulse, sends a header byte and then NUM_BYTES parameter bytes.
- Parameter bytes are read from the telemetry buffer at addresses 0..NUM_BYTES-1.
- Wire format is UART 8N1, LSB first, at a runtime-programmable clk_per_bit. Feeds the RS485 driver enable/data path.

Parameters:
- HEADER, 8'hFE: first byte of every frame.
- NUM_BYTES, 32: parameter bytes per frame, range 1..32.
- ADDR_W, 5: telemetry buffer address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle frame request
- clk_per_bit  in  8  clocks per UART bit
- tlm_rdata  in  8  buffer read data, valid 1 cycle after tlm_rd_en
- tlm_rd_en  out  1  buffer read strobe
- tlm_raddr  out  ADDR_W  buffer read address
- tx  out  1  serial line, idle high
- busy  out  1  high while a frame is in progress
- done  out  1  1-cycle pulse at frame end

Behaviour:
- Reset values: tx=1, busy=0, done=0, tlm_rd_en=0, tlm_raddr=0. The FSM goes to IDLE and all counters clear.
- Reset is synchronous and takes effect mid-frame: at the next edge tx returns to 1 and the frame is abandoned. No done pulse.
- clk_per_bit is latched on start acceptance; changes mid-frame are ignored. A latched value below 2 is forced to 2.
- start is accepted only in IDLE. While busy, start is ignored; there is no queuing.
- Acceptance at edge k: busy=1 and tx=0 (header start bit) from edge k+1.

FSM states: IDLE -> START_BIT -> DATA_BITS -> STOP_BIT -> (next byte START_BIT | FINISH) -> IDLE.
- Each bit is held exactly clk_per_bit cycles, counted by an 8-bit bit-timer.
- DATA_BITS sends shift-register bit 0 first, shifting right 8 times (3-bit bit index).
- Wire value equals the memory byte value: no bit reversal in this block.

Prefetch:
- In the first cycle of each byte's START_BIT, if another byte follows, pulse tlm_rd_en for one cycle with tlm_raddr = next index.
- tlm_rdata is captured into a holding register on the following cycle.
- At the end of STOP_BIT, the holding register loads into the shifter.
- Net effect: bytes are back-to-back with no idle gap.
- Frame length is exactly (NUM_BYTES+1)*10*clk_per_bit cycles.

Sequencing and counters:
- Byte index counter is 6 bits, 0..NUM_BYTES. Read addresses are sequential 0..NUM_BYTES-1, with no wrap within a frame.
- After the last stop bit completes: done=1 for one cycle and busy=0 in that same cycle, tx stays 1.
- Earliest next start is accepted the cycle after done.
- Simultaneous start and reset: reset wins.
- A start in the same cycle as done is ignored, because the block is not yet IDLE.

Decomposition:
- Shared package: UART_IDLE_LVL, FRAME_HEADER (8'hFE), NUM_TLM_PARAMS (32), TLM_ADDR_W (5), and the FSM state encoding. The same constants are used by the receiver.
- One sub-module, uart_tx_serializer:
  - inputs: byte, load strobe, latched clk_per_bit
  - outputs: tx, byte_start pulse, byte_done pulse
- The top level holds the frame FSM, byte index, prefetch and holding register.

Test Plan:
1. clk_per_bit=4, buffer[i]=i+1, start pulse.
   -> Header start bit appears 1 cycle later.
   -> Decoded bytes are FE,01,02..20.
   -> done fires exactly 1320 cycles after tx first falls. busy is high throughout.
   -> tlm_raddr sequence is 0..31, each tlm_rd_en a single-cycle pulse.
2. Per-bit timing, clk_per_bit=10, buffer all 8'hA5.
   -> Every bit lasts 10 cycles.
   -> Pattern per byte is 0,1,0,1,0,0,1,0,1,1 (LSB first).
   -> No idle-high gap between stop and next start.
3. start pulses every 50 cycles during a frame.
   -> Ignored: single frame, single done.
   -> A start one cycle after done launches a new frame.
4. reset asserted at byte 5, bit 3.
   -> Next edge: tx=1, busy=0, tlm_rd_en=0, no done.
   -> A subsequent start produces a complete fresh frame from the header.
5. clk_per_bit=1 and clk_per_bit=0.
   -> Both behave as 2 cycles/bit.
   -> clk_per_bit changed mid-frame from 4 to 8: timing stays at 4 until the next frame.
6. Loopback into the existing command receiver at clk_per_bit=50.
   -> Receiver writes all 32 bytes to addresses 0..31 with values matching the source buffer.

Source files
------------

// File: rtl/tlm_frame_uart_tx_pkg.sv
// Shared constants for the 0xFE-command telemetry serial link (transmitter and receiver).
// Holds line levels, frame layout and the FSM encodings used by the transmit path.
package tlm_frame_uart_tx_pkg;

  localparam logic       UART_IDLE_LVL  = 1'b1;
  localparam logic [7:0] FRAME_HEADER   = 8'hFE;
  localparam int         NUM_TLM_PARAMS = 32;
  localparam int         TLM_ADDR_W     = 5;

  // Bit-level phases of the serializer; ST_FINISH is the frame-level wrap-up cycle.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START_BIT = 3'd1;
  localparam logic [2:0] ST_DATA_BITS = 3'd2;
  localparam logic [2:0] ST_STOP_BIT  = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  localparam logic [1:0] FRM_IDLE   = 2'd0;
  localparam logic [1:0] FRM_ACTIVE = 2'd1;
  localparam logic [1:0] FRM_FINISH = 2'd2;

  localparam logic [7:0] MIN_CLK_PER_BIT = 8'd2;

  function automatic logic [7:0] clamp_clk_per_bit(input logic [7:0] cpb);
    return (cpb < MIN_CLK_PER_BIT) ? MIN_CLK_PER_BIT : cpb;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each clk_per_bit cycles.
// A load during the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_serializer
  import tlm_frame_uart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_byte,
  input  logic       load,
  input  logic [7:0] clk_per_bit,
  output logic       tx,
  output logic       byte_start,
  output logic       byte_done,
  output logic [2:0] phase
);

  logic [2:0] phase_q;
  logic [7:0] bit_timer;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       tx_q;
  logic       bit_end;

  assign bit_end = (bit_timer == (clk_per_bit - 8'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= ST_IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_q      <= UART_IDLE_LVL;
    end else if (load) begin
      phase_q   <= ST_START_BIT;
      bit_timer <= '0;
      bit_idx   <= '0;
      shreg     <= data_byte;
      tx_q      <= ~UART_IDLE_LVL;
    end else begin
      case (phase_q)
        ST_START_BIT: begin
          if (bit_end) begin
            phase_q   <= ST_DATA_BITS;
            bit_timer <= '0;
            tx_q      <= shreg[0];
          end else begin
            bit_timer <= bit_timer + 8'd1;
          end
        end
        ST_DATA_BITS: begin
          if (bit_end) begin
            bit_timer <= '0;
            if (bit_idx == 3'd7) begin
              phase_q <= ST_STOP_BIT;
              tx_q    <= UART_IDLE_LVL;
            end else begin
              // tx follows the bit that becomes shreg[0] after this shift
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            bit_timer <= bit_timer + 8'd1;
          end
        end
        ST_STOP_BIT: begin
          if (bit_end) begin
            phase_q   <= ST_IDLE;
            bit_timer <= '0;
          end else begin
            bit_timer <= bit_timer + 8'd1;
          end
        end
        default: begin
          phase_q   <= ST_IDLE;
          bit_timer <= '0;
          tx_q      <= UART_IDLE_LVL;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign byte_start = (phase_q == ST_START_BIT) && (bit_timer == 8'd0);
  assign byte_done  = (phase_q == ST_STOP_BIT) && bit_end;
  assign phase      = phase_q;

endmodule

// File: rtl/tlm_frame_uart_tx.sv
// Telemetry frame transmitter: header byte then NUM_BYTES buffer bytes over UART 8N1.
// Next byte is prefetched during each start bit so bytes go out back-to-back.
module tlm_frame_uart_tx
  import tlm_frame_uart_tx_pkg::*;
#(
  parameter logic [7:0] HEADER    = FRAME_HEADER,
  parameter int         NUM_BYTES = NUM_TLM_PARAMS,
  parameter int         ADDR_W    = TLM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        clk_per_bit,
  input  logic [7:0]        tlm_rdata,
  output logic              tlm_rd_en,
  output logic [ADDR_W-1:0] tlm_raddr,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  // Handshakes: start is a 1-cycle request honoured only in idle, no queuing;
  // tlm_rd_en is a 1-cycle strobe and tlm_rdata is taken the cycle after it.
  localparam logic [5:0] LAST_IDX = 6'(NUM_BYTES);

  logic [1:0] frame_q;
  logic [5:0] byte_idx;
  logic [7:0] cpb_lat;
  logic [7:0] hold_q;
  logic       rd_pending;
  logic       ser_load;
  logic [7:0] ser_byte;
  logic       byte_start;
  logic       byte_done;
  logic [2:0] ser_phase;
  logic       more_bytes;

  assign more_bytes = (byte_idx < LAST_IDX);

  always_comb begin
    ser_load = 1'b0;
    ser_byte = HEADER;
    if (frame_q == FRM_IDLE && start) begin
      ser_load = 1'b1;
    end else if (frame_q == FRM_ACTIVE && byte_done && more_bytes) begin
      ser_load = 1'b1;
      ser_byte = hold_q;
    end
  end

  // byte_idx names the byte on the wire; buffer entry byte_idx is the byte after it.
  assign tlm_rd_en = (frame_q == FRM_ACTIVE) && byte_start && more_bytes;
  assign tlm_raddr = byte_idx[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q    <= FRM_IDLE;
      byte_idx   <= '0;
      cpb_lat    <= MIN_CLK_PER_BIT;
      hold_q     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= tlm_rd_en;
      if (rd_pending) hold_q <= tlm_rdata;
      case (frame_q)
        FRM_IDLE: begin
          if (start) begin
            frame_q  <= FRM_ACTIVE;
            byte_idx <= '0;
            cpb_lat  <= clamp_clk_per_bit(clk_per_bit);
          end
        end
        FRM_ACTIVE: begin
          if (byte_done) begin
            if (more_bytes) begin
              byte_idx <= byte_idx + 6'd1;
            end else begin
              frame_q  <= FRM_FINISH;
              byte_idx <= '0;
            end
          end
        end
        FRM_FINISH: frame_q <= FRM_IDLE;
        default:    frame_q <= FRM_IDLE;
      endcase
    end
  end

  uart_tx_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .data_byte  (ser_byte),
    .load       (ser_load),
    .clk_per_bit(cpb_lat),
    .tx         (tx),
    .byte_start (byte_start),
    .byte_done  (byte_done),
    .phase      (ser_phase)
  );

  assign busy = (frame_q == FRM_ACTIVE);
  assign done = (frame_q == FRM_FINISH);

  always_comb begin
    state_dbg = ST_IDLE;
    case (frame_q)
      FRM_ACTIVE: state_dbg = ser_phase;
      FRM_FINISH: state_dbg = ST_FINISH;
      default:    state_dbg = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlm_frame_uart_tx.sv
// Bench for tlm_frame_uart_tx: expected line waveform is derived from the byte list
// (header + buffer) and UART 8N1 framing; a mid-bit sampler decodes the bytes back.
module tb_tlm_frame_uart_tx;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] clk_per_bit = 8'd4;
  logic [7:0] tlm_rdata = 8'h00;
  logic       tlm_rd_en;
  logic [4:0] tlm_raddr;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem   [N];
  logic [7:0] exp_b [N+1];
  logic [7:0] exp_q [$];

  tlm_frame_uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clk_per_bit(clk_per_bit),
    .tlm_rdata  (tlm_rdata),
    .tlm_rd_en  (tlm_rd_en),
    .tlm_raddr  (tlm_raddr),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // telemetry buffer: registered read, data one cycle after the strobe
  always @(posedge clk) if (tlm_rd_en) tlm_rdata <= mem[tlm_raddr];

  function automatic logic exp_tx(input int c, input int cpb);
    int p  = c / cpb;
    int b  = p / 10;
    int bp = p % 10;
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return exp_b[b][bp-1];
  endfunction

  task automatic build_exp();
    exp_b[0] = 8'hFE;
    for (int i = 0; i < N; i++) exp_b[i+1] = mem[i];
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic launch(input logic [7:0] cpb);
    @(negedge clk);
    clk_per_bit = cpb;
    start = 1'b1;
    @(posedge clk);
  endtask

  // Follows one frame from the cycle after acceptance. chain: after the done cycle
  // (with start held through it), assert start in the next idle cycle.
  task automatic check_frame(input string name, input int cpb, input int start_every,
                             input int chg_at, input int abort_at, input bit chain);
    int L = (N + 1) * 10 * cpb;
    int c = 0;
    int done_cyc = -1;
    int tx_err = 0;
    int busy_err = 0;
    int pulse_err = 0;
    int addr_err = 0;
    int late_done = 0;
    logic prev_rd = 1'b0;
    logic [4:0] addr_q [$];
    logic [7:0] dec [N+1];
    logic [7:0] got;
    logic [7:0] want;
    build_exp();
    while (done_cyc < 0 && c <= L + 20) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_cyc = c;
      end else begin
        if (c < L) begin
          int p  = c / cpb;
          int bp = p % 10;
          if (tx !== exp_tx(c, cpb)) tx_err++;
          if (busy !== 1'b1) busy_err++;
          if ((c % cpb) == cpb / 2 && bp >= 1 && bp <= 8) dec[p / 10][bp-1] = tx;
        end
        if (tlm_rd_en === 1'b1) begin
          if (prev_rd) pulse_err++;
          addr_q.push_back(tlm_raddr);
        end
        prev_rd = tlm_rd_en;
        if (c == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          n_vec++; if (tx_err != 0) begin n_err++; $display("FAIL %s wire before abort: %0d bad cycles, want 0", name, tx_err); end
          n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL %s tx after reset: got %b want 1", name, tx); end
          n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy after reset: got %b want 0", name, busy); end
          n_vec++; if (tlm_rd_en !== 1'b0) begin n_err++; $display("FAIL %s rd_en after reset: got %b want 0", name, tlm_rd_en); end
          n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done after reset: got %b want 0", name, done); end
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) late_done++;
          end
          n_vec++; if (late_done != 0) begin n_err++; $display("FAIL %s idle after abort: %0d bad cycles, want 0", name, late_done); end
          return;
        end
        if (start_every > 0 && c > 0 && (c % start_every) == 0) start = 1'b1;
        if (c == chg_at) clk_per_bit = 8'd8;
        c++;
      end
    end

    n_vec++;
    if (done_cyc != L) begin n_err++; $display("FAIL %s done latency: got %0d want %0d", name, done_cyc, L); end
    if (done_cyc >= 0) begin
      n_vec++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        n_err++; $display("FAIL %s done cycle busy/tx: got %b/%b want 0/1", name, busy, tx);
      end
      if (chain) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
        n_err++; $display("FAIL %s after done done/busy/tx: got %b/%b/%b want 0/0/1", name, done, busy, tx);
      end
      if (chain) begin
        start = 1'b1;
        @(posedge clk);
      end
    end
    n_vec++; if (tx_err != 0) begin n_err++; $display("FAIL %s wire: %0d bad cycles, want 0", name, tx_err); end
    n_vec++; if (busy_err != 0) begin n_err++; $display("FAIL %s busy: %0d low cycles, want 0", name, busy_err); end
    for (int i = 0; i < addr_q.size() && i < N; i++) if (addr_q[i] !== 5'(i)) addr_err++;
    n_vec++;
    if (addr_q.size() != N || addr_err != 0 || pulse_err != 0) begin
      n_err++;
      $display("FAIL %s reads: got %0d strobes %0d bad addr %0d long pulses, want %0d/0/0",
               name, addr_q.size(), addr_err, pulse_err, N);
    end
    exp_q.delete();
    exp_q.push_back(8'hFE);
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    for (int b = 0; b <= N; b++) begin
      got  = dec[b];
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL %s byte %0d: got %h want %h", name, b, got, want); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; clk_per_bit = 8'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
    n_vec++; if (tlm_rd_en !== 1'b0) begin n_err++; $display("FAIL reset rd_en: got %b want 0", tlm_rd_en); end
    n_vec++; if (tlm_raddr !== 5'd0) begin n_err++; $display("FAIL reset raddr: got %0d want 0", tlm_raddr); end
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_vec++; if (busy !== 1'b0 || tx !== 1'b1) begin n_err++; $display("FAIL reset_vs_start busy/tx: got %b/%b want 0/1", busy, tx); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || tx !== 1'b1) begin n_err++; $display("FAIL reset_vs_start later busy/tx: got %b/%b want 0/1", busy, tx); end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < N; i++) mem[i] = 8'(i + 1);
    launch(8'd4);
    check_frame("basic", 4, 0, -1, -1, 1'b0);
  endtask

  task automatic test_bit_timing();
    for (int i = 0; i < N; i++) mem[i] = 8'hA5;
    launch(8'd10);
    check_frame("a5_cpb10", 10, 0, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    launch(8'd4);
    check_frame("ignored_starts", 4, 50, -1, -1, 1'b1);
    fill_random();
    check_frame("chained_frame", 4, 0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    fill_random();
    launch(8'd4);
    check_frame("abort", 4, 0, -1, (5 * 10 + 4) * 4 + 1, 1'b0);
    fill_random();
    launch(8'd4);
    check_frame("after_abort", 4, 0, -1, -1, 1'b0);
  endtask

  task automatic test_clk_per_bit();
    fill_random();
    launch(8'd1);
    check_frame("cpb1", 2, 0, -1, -1, 1'b0);
    fill_random();
    launch(8'd0);
    check_frame("cpb0", 2, 0, -1, -1, 1'b0);
    fill_random();
    launch(8'd4);
    check_frame("cpb_change", 4, 0, 100, -1, 1'b0);
    launch(8'd8);
    check_frame("cpb8", 8, 0, -1, -1, 1'b0);
  endtask

  task automatic test_loopback();
    fill_random();
    launch(8'd50);
    check_frame("loopback_cpb50", 50, 0, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bit_timing();
    test_back_to_back();
    test_reset_midframe();
    test_clk_per_bit();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
